// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the writeback stage (A)
// and the multicycle unit (B), and tracks registers with in-flight B results.
module regfile_write_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_reg,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_reg,
   input  logic [31:0] b_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_reg,
   input  logic [4:0]  q_reg1,
   input  logic [4:0]  q_reg2,
   output logic        q_busy1,
   output logic        q_busy2,
   output logic        write,
   output logic [4:0]  write_reg,
   output logic [31:0] write_data
);

   localparam logic [3:0] AGE_LIMIT = 4'(STARVE_LIMIT);
   localparam logic [3:0] AGE_MAX   = 4'd15;

   logic        hold_full;
   logic [4:0]  hold_reg;
   logic [31:0] hold_data;
   logic [3:0]  hold_age;
   logic        src_b;
   logic [31:0] busy;
   logic [31:0] busy_nxt;

   logic force_b;
   logic grant_a;
   logic grant_b;
   logic b_load;

   always_comb begin
      force_b = hold_full && (hold_age >= AGE_LIMIT);
      grant_b = hold_full && (!a_valid || force_b);
      grant_a = a_valid && !grant_b;
      a_ready = !grant_b;
      b_ready = !hold_full || grant_b;
      b_load  = b_valid && b_ready;
      q_busy1 = busy[q_reg1];
      q_busy2 = busy[q_reg2];
   end

   // A load in the same cycle as a grant refills the slot the grant just emptied.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_full <= 1'b0;
         hold_reg  <= '0;
         hold_data <= '0;
         hold_age  <= '0;
      end else if (b_load) begin
         hold_full <= 1'b1;
         hold_reg  <= b_reg;
         hold_data <= b_data;
         hold_age  <= '0;
      end else if (grant_b) begin
         hold_full <= 1'b0;
         hold_age  <= '0;
      end else if (hold_full && (hold_age != AGE_MAX)) begin
         hold_age  <= hold_age + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write      <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         src_b      <= 1'b0;
      end else if (grant_a) begin
         write      <= (a_reg != 5'd0);
         write_reg  <= a_reg;
         write_data <= a_data;
         src_b      <= 1'b0;
      end else if (grant_b) begin
         write      <= (hold_reg != 5'd0);
         write_reg  <= hold_reg;
         write_data <= hold_data;
         src_b      <= 1'b1;
      end else begin
         write      <= 1'b0;
      end
   end

   // Clear is applied before set so a re-issue in the clearing cycle keeps the bit.
   always_comb begin
      busy_nxt = busy;
      if (write && src_b) begin
         busy_nxt[write_reg] = 1'b0;
      end
      if (iss_valid && (iss_reg != 5'd0)) begin
         busy_nxt[iss_reg] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected register file writes are queued
// when requests are driven and matched in order as the write port fires.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, a_ready;
   logic [4:0]  a_reg;
   logic [31:0] a_data;
   logic        b_valid, b_ready;
   logic [4:0]  b_reg;
   logic [31:0] b_data;
   logic        iss_valid;
   logic [4:0]  iss_reg;
   logic [4:0]  q_reg1, q_reg2;
   logic        q_busy1, q_busy2;
   logic        write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   wr_t expq[$];
   int  vectors    = 0;
   int  miscompares = 0;

   regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .iss_valid(iss_valid), .iss_reg(iss_reg),
      .q_reg1(q_reg1), .q_reg2(q_reg2), .q_busy1(q_busy1), .q_busy2(q_busy2),
      .write(write), .write_reg(write_reg), .write_data(write_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [4:0] r, input logic [31:0] d);
      wr_t e;
      e.r = r;
      e.d = d;
      expq.push_back(e);
   endtask

   task automatic drain(input string tag);
      tick();
      tick();
      check(tag, expq.size(), 0);
      expq.delete();
   endtask

   // Every write the DUT performs must be the next queued expectation.
   always @(negedge clk) begin
      if (rst && write) begin
         if (expq.size() == 0) begin
            check("unexpected_write", write, 1'b0);
         end else begin
            wr_t e;
            e = expq.pop_front();
            check("write_reg", write_reg, e.r);
            check("write_data", write_data, e.d);
         end
      end
   end

   initial begin
      rst = 1'b0;
      a_valid = 0; a_reg = '0; a_data = '0;
      b_valid = 0; b_reg = '0; b_data = '0;
      iss_valid = 0; iss_reg = '0;
      q_reg1 = '0; q_reg2 = '0;
      tick();
      #1;
      check("rst_write", write, 0);
      check("rst_write_reg", write_reg, 0);
      check("rst_write_data", write_data, 0);
      check("rst_b_ready", b_ready, 1);
      check("rst_a_ready", a_ready, 1);
      check("rst_q_busy1", q_busy1, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // A only
      a_valid = 1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
      #1 check("a_only_ready", a_ready, 1);
      push(5'd5, 32'hDEADBEEF);
      tick();
      a_valid = 0;
      check("a_only_write", write, 1);
      check("a_only_reg", write_reg, 5);
      tick();
      check("a_only_idle", write, 0);
      drain("a_only_drain");

      // Scoreboard set/clear, re-issue in the clearing cycle
      q_reg1 = 5'd9;
      iss_valid = 1; iss_reg = 5'd9;
      #1 check("sb_pre_issue", q_busy1, 0);
      tick();
      iss_valid = 0;
      #1 check("sb_after_issue", q_busy1, 1);
      b_valid = 1; b_reg = 5'd9; b_data = 32'h12345678;
      #1 check("sb_b_ready", b_ready, 1);
      push(5'd9, 32'h12345678);
      tick();
      b_valid = 0;
      #1 check("sb_held", q_busy1, 1);
      tick();
      check("sb_write", write, 1);
      check("sb_busy_until_land", q_busy1, 1);
      iss_valid = 1; iss_reg = 5'd9;
      tick();
      iss_valid = 0;
      #1 check("sb_reissue_wins", q_busy1, 1);
      b_valid = 1; b_reg = 5'd9; b_data = 32'h0000_0099;
      push(5'd9, 32'h0000_0099);
      tick();
      b_valid = 0;
      tick();
      check("sb_busy_before_land2", q_busy1, 1);
      tick();
      check("sb_cleared", q_busy1, 0);
      drain("sb_drain");

      // Contention with starvation bound of 4
      a_valid = 1; a_reg = 5'd10; a_data = 32'hA000_0010;
      b_valid = 1; b_reg = 5'd3; b_data = 32'hB000_0003;
      #1 check("ct_a_ready0", a_ready, 1);
      check("ct_b_ready0", b_ready, 1);
      push(5'd10, 32'hA000_0010);
      tick();
      b_valid = 0;
      for (int i = 1; i <= 4; i++) begin
         a_reg = 5'(10 + i);
         a_data = 32'hA000_0010 + 32'(i);
         #1 check($sformatf("ct_a_wins%0d", i), a_ready, 1);
         check($sformatf("ct_b_blocked%0d", i), b_ready, 0);
         push(a_reg, a_data);
         tick();
      end
      a_reg = 5'd15; a_data = 32'hA000_0015;
      #1 check("ct_forced_a_ready", a_ready, 0);
      check("ct_forced_b_ready", b_ready, 1);
      push(5'd3, 32'hB000_0003);
      tick();
      check("ct_forced_write_reg", write_reg, 3);
      #1 check("ct_resume_a_ready", a_ready, 1);
      push(5'd15, 32'hA000_0015);
      tick();
      a_valid = 0;
      drain("ct_drain");

      // Register 0
      a_valid = 1; a_reg = 5'd0; a_data = 32'hFFFFFFFF;
      iss_valid = 1; iss_reg = 5'd0; q_reg2 = 5'd0;
      #1 check("r0_a_ready", a_ready, 1);
      tick();
      a_valid = 0; iss_valid = 0;
      check("r0_no_write", write, 0);
      #1 check("r0_q_busy2", q_busy2, 0);
      drain("r0_drain");

      // Back-to-back B with A idle
      for (int i = 1; i <= 3; i++) begin
         b_valid = 1; b_reg = 5'(i); b_data = 32'hC000_0000 + 32'(i);
         #1 check($sformatf("bb_b_ready%0d", i), b_ready, 1);
         push(b_reg, b_data);
         tick();
         if (i > 1) check($sformatf("bb_write%0d", i - 1), write, 1);
      end
      b_valid = 0;
      tick();
      check("bb_write3", write, 1);
      drain("bb_drain");

      // Reset mid-operation discards held B and pending bits
      iss_valid = 1; iss_reg = 5'd7; q_reg1 = 5'd7;
      tick();
      iss_valid = 0;
      a_valid = 1; a_reg = 5'd20; a_data = 32'h2020_2020;
      b_valid = 1; b_reg = 5'd7; b_data = 32'h7777_7777;
      push(5'd20, 32'h2020_2020);
      tick();
      #1 check("mr_busy_before", q_busy1, 1);
      rst = 1'b0;
      #1;
      check("mr_write", write, 0);
      check("mr_b_ready", b_ready, 1);
      check("mr_q_busy1", q_busy1, 0);
      a_valid = 0; b_valid = 0;
      expq.delete();
      tick();
      rst = 1'b1;
      tick();
      check("mr_held_lost", write, 0);
      drain("mr_drain");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writers: the main pipeline writeback stage (requester A) and the multicycle unit (requester B, e.g. mult/div or a slow load path). Holds one pending B result in a holding register, gives A priority, and bounds B starvation by back-pressuring A. Keeps a per-register pending scoreboard for B destinations so decode can stall on RAW hazards against in-flight multicycle results. Sits between writeback/multicycle unit and the register file's write, write_reg and write_data inputs.

## Interface
- STARVE_LIMIT, 4: cycles a held B result may lose to A before B is forced through (1..15)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- a_valid  in  1  pipeline writeback request
- a_ready  out  1  A accepted this cycle; combinational
- a_reg  in  5  A destination register
- a_data  in  32  A write data
- b_valid  in  1  multicycle unit result valid
- b_ready  out  1  holding register can accept B this cycle; combinational
- b_reg  in  5  B destination register
- b_data  in  32  B write data
- iss_valid  in  1  multicycle op issued this cycle; marks iss_reg pending
- iss_reg  in  5  destination of the issued multicycle op
- q_reg1, q_reg2  in  5 each  decode source registers to check
- q_busy1, q_busy2  out  1 each  source has a pending B write; combinational
- write  out  1  register file write enable; registered
- write_reg  out  5  register file write select; registered
- write_data  out  32  register file write data; registered

## Operation
- Holding register: hold_full, hold_reg, hold_data, hold_age (4 bits). Loads on b_valid & b_ready.
- force_b = hold_full & (hold_age >= STARVE_LIMIT).
- grant_b = hold_full & (!a_valid | force_b). grant_a = a_valid & !grant_b.
- a_ready = !grant_b. b_ready = !hold_full | grant_b; back-to-back B results therefore flow at one per cycle when A is idle.
- hold_age: cleared on load and on grant; increments, saturating at 15, each cycle hold_full & !grant_b.
- On grant_a: write<=1, write_reg<=a_reg, write_data<=a_data, src_b<=0. On grant_b: same with hold_reg/hold_data, src_b<=1. Otherwise write<=0; write_reg and write_data hold their values.
- Register 0: a grant with destination 0 completes the handshake but drives write<=0.
- Scoreboard busy[31:1], busy[0] fixed 0. Set busy[iss_reg] on iss_valid (iss_reg != 0). Clear busy[write_reg] when write & src_b, on the same edge the register file stores the value. If set and clear hit the same register in one cycle, set wins.
- q_busyN = busy[q_regN]. q_reg 0 always reads not busy.
- The arbiter performs no WAW check on A writes. Decode must stall on q_busy before issuing an A writer to a pending register.

## Timing
- Reset (rst low, asynchronous): write=0, write_reg=0, write_data=0, src_b=0, hold_full=0, hold_age=0, busy all 0.
- Reset mid-operation discards any held B result and all pending bits. Outputs are valid from the first clk edge after rst rises.
- A latency: accepted at edge N, write asserted during cycle N+1, register file updated at edge N+1.
- B latency: captured at edge N, earliest grant in cycle N+1, write during N+2, busy cleared at edge N+2.
- Maximum B wait with continuous A traffic: STARVE_LIMIT cycles. In the forced cycle a_ready=0, and A must hold a_valid, a_reg and a_data.
- At most one register file write per cycle. write is never asserted for register 0.

## Test plan
- Reset: drive all requests mid-stream, pull rst low between edges -> write=0, b_ready=1, q_busy1=0 immediately; held B lost.
- A only: a_valid with a_reg=5, a_data=0xDEADBEEF at edge N -> write=1, write_reg=5, write_data=0xDEADBEEF in cycle N+1; a_ready stays 1.
- Scoreboard: iss_reg=9, then B writes reg 9 with 0x12345678 -> q_busy1 (q_reg1=9) is 1 from the cycle after issue until the edge where the write lands, then 0. Issue reg 9 again in the clear cycle -> stays 1.
- Contention: a_valid continuous, one B result to reg 3, STARVE_LIMIT=4 -> B loses 4 cycles; in cycle 5 a_ready=0 and grant_b; next cycle write_reg=3; A resumes with no lost write.
- Register 0: A write to reg 0 with data 0xFFFFFFFF -> a_ready=1, write stays 0. iss_reg=0 -> q_busy for reg 0 stays 0.
- Back-to-back B: A idle, b_valid for 3 consecutive cycles (regs 1, 2, 3) -> b_ready held 1, three consecutive writes to 1, 2, 3.
